// File: rtl/simon_key_expand.sv
// simon_key_expand -- sequential Simon key-schedule engine (all ten N/M pairs).
// Ports: clk, rst (sync, active-high); key_in/key_valid/key_ready master-key
//        load; rk_data/rk_idx/rk_valid/rk_ready/rk_last round-key stream.
// Optional (SIMON_KEY_STORE_EN): T x N round-key store read via rd_addr ->
//        rd_data (registered, 1 cycle), plus keys_done flag.
//
// Purpose: load an M-word master key, stream round keys k[0]..k[T-1] in order.
// Latency: key handshake in cycle 0 -> k[0] valid in cycle 1, one key per cycle.
// Backpressure: rk_ready low holds rk_data/rk_idx/rk_valid; key_ready low in RUN.
module simon_key_expand #(
   parameter int N = 16,
   parameter int M = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [M*N-1:0] key_in,
   input  logic           key_valid,
   output logic           key_ready,
   output logic [N-1:0]   rk_data,
   output logic [6:0]     rk_idx,
   output logic           rk_valid,
   input  logic           rk_ready,
   output logic           rk_last
`ifdef SIMON_KEY_STORE_EN
   ,
   input  logic [6:0]     rd_addr,
   output logic [N-1:0]   rd_data,
   output logic           keys_done
`endif
);

   localparam int T =
      (N == 16 && M == 4) ? 32 :
      (N == 24 && M == 3) ? 36 :
      (N == 24 && M == 4) ? 36 :
      (N == 32 && M == 3) ? 42 :
      (N == 32 && M == 4) ? 44 :
      (N == 48 && M == 2) ? 52 :
      (N == 48 && M == 3) ? 54 :
      (N == 64 && M == 2) ? 68 :
      (N == 64 && M == 3) ? 69 :
      (N == 64 && M == 4) ? 72 : 0;

   localparam int ZJ =
      (N == 24 && M == 4) ? 1 :
      (N == 32 && M == 3) ? 2 :
      (N == 32 && M == 4) ? 3 :
      (N == 48 && M == 2) ? 2 :
      (N == 48 && M == 3) ? 3 :
      (N == 64 && M == 2) ? 2 :
      (N == 64 && M == 3) ? 3 :
      (N == 64 && M == 4) ? 4 : 0;

   if (T == 0) begin : g_bad_cfg
      $error("simon_key_expand: unsupported (N,M) pair");
   end

   // The z sequences are written below in published order (first element on
   // the left) and bit-reversed so that bit 0 holds the first element.
   function automatic logic [63:0] z_seq(input int j);
      logic [61:0] pub;
      logic [63:0] seq;
      case (j)
         0:       pub = 62'b11111010001001010110000111001101111101000100101011000011100110;
         1:       pub = 62'b10001110111110010011000010110101000111011111001001100001011010;
         2:       pub = 62'b10101111011100000011010010011000101000010001111110010110110011;
         3:       pub = 62'b11011011101011000110010111100000010010001010011100110100001111;
         default: pub = 62'b11010001111001101011011000100000010111000011001010010011101111;
      endcase
      seq = '0;
      for (int b = 0; b < 62; b++) seq[b] = pub[61-b];
      return seq;
   endfunction

   localparam logic [63:0]  ZSEQ = z_seq(ZJ);
   localparam logic [N-1:0] C3   = {{(N-2){1'b0}}, 2'b11};

   typedef enum logic {IDLE, RUN} state_t;

   state_t       state_q;
   logic [N-1:0] win_q [M];     // sliding window W[0..M-1], W[0] is on rk_data
   logic [6:0]   rk_idx_q;
   logic         rk_valid_q;
   logic [5:0]   zcnt_q;        // rk_idx mod 62, kept as a wrapping counter

   logic [N-1:0] rot3, mix, tmp, knew;
   logic         rk_fire, last_fire;

   assign rk_fire   = rk_valid_q & rk_ready;
   assign last_fire = rk_fire & (rk_idx_q == 7'(T-1));

   // Next schedule word k[i+M] from the current window (i = rk_idx).
   assign rot3 = {win_q[M-1][2:0], win_q[M-1][N-1:3]};
   assign mix  = (M == 4) ? (rot3 ^ win_q[1]) : rot3;
   assign tmp  = mix ^ {mix[0], mix[N-1:1]};
   assign knew = ~win_q[0] ^ tmp ^ C3 ^ {{(N-1){1'b0}}, ZSEQ[zcnt_q]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rk_idx_q   <= '0;
         rk_valid_q <= 1'b0;
         zcnt_q     <= '0;
         for (int j = 0; j < M; j++) win_q[j] <= '0;
      end else begin
         case (state_q)
            // key_ready is exactly (IDLE && !rst), so key_valid alone completes it here
            IDLE: begin
               if (key_valid) begin
                  for (int j = 0; j < M; j++) win_q[j] <= key_in[j*N +: N];
                  rk_idx_q   <= '0;
                  zcnt_q     <= '0;
                  rk_valid_q <= 1'b1;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               if (rk_fire) begin
                  for (int j = 0; j < M-1; j++) win_q[j] <= win_q[j+1];
                  win_q[M-1] <= knew;
                  zcnt_q     <= (zcnt_q == 6'd61) ? 6'd0 : zcnt_q + 6'd1;
                  if (last_fire) begin
                     // rk_idx stays at T-1 so it never leaves its 0..T-1 range
                     rk_valid_q <= 1'b0;
                     state_q    <= IDLE;
                  end else begin
                     rk_idx_q <= rk_idx_q + 7'd1;
                  end
               end
            end
         endcase
      end
   end

   assign key_ready = (state_q == IDLE) & ~rst;
   assign rk_data   = win_q[0];
   assign rk_idx    = rk_idx_q;
   assign rk_valid  = rk_valid_q;
   assign rk_last   = rk_valid_q & (rk_idx_q == 7'(T-1));

`ifdef SIMON_KEY_STORE_EN
   localparam int AW = $clog2(T);

   logic [N-1:0] store_q [T];   // deliberately not reset
   logic [N-1:0] rd_data_q;
   logic         keys_done_q;

   always_ff @(posedge clk) begin
      if (rk_fire && !rst) store_q[rk_idx_q[AW-1:0]] <= win_q[0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q   <= '0;
         keys_done_q <= 1'b0;
      end else begin
         rd_data_q <= (rd_addr < 7'(T)) ? store_q[rd_addr[AW-1:0]] : '0;
         if (state_q == IDLE && key_valid) keys_done_q <= 1'b0;
         else if (last_fire)               keys_done_q <= 1'b1;
      end
   end

   assign rd_data   = rd_data_q;
   assign keys_done = keys_done_q;
`endif

endmodule

// File: tb/tb_simon_key_expand.sv
// tb_simon_key_expand -- bench for simon_key_expand across all ten (N,M) pairs.
// One DUT per configuration; tasks drive each scenario and compare the stream
// against a queue of expected round keys produced by an independent model.
`timescale 1ns/1ps
module tb_simon_key_expand;

   localparam int NCFG = 10;
   localparam int CN [NCFG] = '{16, 24, 24, 32, 32, 48, 48, 64, 64, 64};
   localparam int CM [NCFG] = '{ 4,  3,  4,  3,  4,  2,  3,  2,  3,  4};
   localparam int CT [NCFG] = '{32, 36, 36, 42, 44, 52, 54, 68, 69, 72};
   localparam int CZ [NCFG] = '{ 0,  0,  1,  2,  3,  2,  3,  2,  3,  4};

   typedef struct packed {
      logic [6:0]  idx;
      logic [63:0] dat;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic [255:0] key_in_a    [NCFG];
   logic         key_valid_a [NCFG];
   logic         rk_ready_a  [NCFG];
   logic         key_ready_a [NCFG];
   logic         rk_valid_a  [NCFG];
   logic         rk_last_a   [NCFG];
   logic [63:0]  rk_data_a   [NCFG];
   logic [6:0]   rk_idx_a    [NCFG];
`ifdef SIMON_KEY_STORE_EN
   logic [6:0]   rd_addr_a   [NCFG];
   logic [63:0]  rd_data_a   [NCFG];
   logic         keys_done_a [NCFG];
`endif

   exp_t        sb_q [$];
   logic [63:0] got_keys [0:127];
   int          checks = 0;
   int          errors = 0;

   for (genvar g = 0; g < NCFG; g++) begin : g_dut
      localparam int GN = CN[g];
      localparam int GM = CM[g];
      logic [GN-1:0] rkd;
      logic [6:0]    rki;
      logic          kr, rv, rl;
`ifdef SIMON_KEY_STORE_EN
      logic [GN-1:0] rdd;
      logic          kd;
`endif
      simon_key_expand #(.N(GN), .M(GM)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .key_in    (key_in_a[g][GM*GN-1:0]),
         .key_valid (key_valid_a[g]),
         .key_ready (kr),
         .rk_data   (rkd),
         .rk_idx    (rki),
         .rk_valid  (rv),
         .rk_ready  (rk_ready_a[g]),
         .rk_last   (rl)
`ifdef SIMON_KEY_STORE_EN
         ,
         .rd_addr   (rd_addr_a[g]),
         .rd_data   (rdd),
         .keys_done (kd)
`endif
      );
      assign rk_data_a[g]   = 64'(rkd);
      assign rk_idx_a[g]    = rki;
      assign key_ready_a[g] = kr;
      assign rk_valid_a[g]  = rv;
      assign rk_last_a[g]   = rl;
`ifdef SIMON_KEY_STORE_EN
      assign rd_data_a[g]   = 64'(rdd);
      assign keys_done_a[g] = kd;
`endif
   end

   // ---------------- reference model ----------------
   function automatic bit zbit(input int j, input int i);
      logic [61:0] s;
      case (j)
         0:       s = 62'b11111010001001010110000111001101111101000100101011000011100110;
         1:       s = 62'b10001110111110010011000010110101000111011111001001100001011010;
         2:       s = 62'b10101111011100000011010010011000101000010001111110010110110011;
         3:       s = 62'b11011011101011000110010111100000010010001010011100110100001111;
         default: s = 62'b11010001111001101011011000100000010111000011001010010011101111;
      endcase
      return s[61-i];
   endfunction

   function automatic logic [63:0] wmask(input int n);
      return (n == 64) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << n) - 64'd1);
   endfunction

   function automatic logic [63:0] ror(input logic [63:0] x, input int r, input int n);
      return ((x >> r) | (x << (n - r))) & wmask(n);
   endfunction

   function automatic logic [63:0] rol64(input logic [63:0] x, input int r);
      return (x << r) | (x >> (64 - r));
   endfunction

   task automatic model_push(input int g, input logic [255:0] key);
      int          n, m, t;
      logic [63:0] mask, tmp;
      logic [63:0] k [0:71];
      exp_t        e;
      n = CN[g]; m = CM[g]; t = CT[g];
      mask = wmask(n);
      for (int i = 0; i < m; i++) k[i] = 64'(key >> (i * n)) & mask;
      for (int i = m; i < t; i++) begin
         tmp = ror(k[i-1], 3, n);
         if (m == 4) tmp = tmp ^ k[i-3];
         tmp = tmp ^ ror(tmp, 1, n);
         k[i] = (~k[i-m] ^ tmp ^ 64'd3 ^ {63'd0, zbit(CZ[g], (i - m) % 62)}) & mask;
      end
      sb_q.delete();
      for (int i = 0; i < t; i++) begin
         e.idx = 7'(i);
         e.dat = k[i];
         sb_q.push_back(e);
      end
   endtask

   function automatic logic [127:0] simon128_enc(input logic [127:0] pt);
      logic [63:0] x, y, tmp;
      x = pt[127:64];
      y = pt[63:0];
      for (int r = 0; r < 68; r++) begin
         tmp = x;
         x   = y ^ (rol64(x, 1) & rol64(x, 8)) ^ rol64(x, 2) ^ got_keys[r];
         y   = tmp;
      end
      return {x, y};
   endfunction

   function automatic logic [255:0] rand_key();
      return {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom};
   endfunction

   // Load `key` on config g and consume the whole stream, comparing each
   // handshake with the scoreboard. stall_pct: % of cycles with rk_ready low.
   // hold_kv keeps key_valid high (with alt_key) while running. abort_at >= 0
   // pulses rst when that index is presented and returns.
   task automatic stream(input int g, input logic [255:0] key, input int stall_pct,
                         input bit hold_kv, input logic [255:0] alt_key, input int abort_at);
      int          t, seen, cyc;
      bit          was_stall;
      logic [63:0] held_dat;
      logic [6:0]  held_idx;
      exp_t        e;
      t = CT[g];
      held_dat = '0; held_idx = '0;
      model_push(g, key);
      @(negedge clk);
      key_in_a[g] = key; key_valid_a[g] = 1'b1; rk_ready_a[g] = 1'b0;
      checks++;
      if (key_ready_a[g] !== 1'b1) begin
         errors++; $display("FAIL key_ready_idle cfg%0d got %b want 1", g, key_ready_a[g]);
      end
      @(negedge clk);
      if (hold_kv) key_in_a[g] = alt_key;
      else key_valid_a[g] = 1'b0;
      checks++;
      if (rk_valid_a[g] !== 1'b1) begin
         errors++; $display("FAIL first_key_latency cfg%0d rk_valid got %b want 1", g, rk_valid_a[g]);
      end
      seen = 0; cyc = 0; was_stall = 1'b0;
      while (seen < t && cyc < 1000) begin
         if (was_stall) begin
            checks++;
            if ({rk_idx_a[g], rk_data_a[g]} !== {held_idx, held_dat}) begin
               errors++; $display("FAIL stall_hold cfg%0d got %0d:%h want %0d:%h",
                                  g, rk_idx_a[g], rk_data_a[g], held_idx, held_dat);
            end
         end
         checks++;
         if (rk_valid_a[g] !== 1'b1) begin
            errors++; $display("FAIL valid_drop cfg%0d after %0d keys got %b want 1", g, seen, rk_valid_a[g]);
            break;
         end
         if (abort_at >= 0 && seen == abort_at) begin
            checks++;
            if (rk_idx_a[g] !== 7'(abort_at)) begin
               errors++; $display("FAIL abort_idx cfg%0d got %0d want %0d", g, rk_idx_a[g], abort_at);
            end
            rst = 1'b1;
            @(negedge clk);
            checks++;
            if (rk_valid_a[g] !== 1'b0) begin
               errors++; $display("FAIL abort_rk_valid cfg%0d got %b want 0", g, rk_valid_a[g]);
            end
            checks++;
            if (key_ready_a[g] !== 1'b0) begin
               errors++; $display("FAIL abort_key_ready cfg%0d got %b want 0", g, key_ready_a[g]);
            end
            rst = 1'b0; key_valid_a[g] = 1'b0; rk_ready_a[g] = 1'b0;
            @(negedge clk);
            return;
         end
         rk_ready_a[g] = ($urandom_range(0, 99) >= stall_pct);
         if (rk_ready_a[g]) begin
            e = sb_q.pop_front();
            checks++;
            if (rk_idx_a[g] !== e.idx) begin
               errors++; $display("FAIL rk_idx cfg%0d got %0d want %0d", g, rk_idx_a[g], e.idx);
            end
            checks++;
            if (rk_data_a[g] !== e.dat) begin
               errors++; $display("FAIL rk_data cfg%0d idx%0d got %h want %h", g, e.idx, rk_data_a[g], e.dat);
            end
            checks++;
            if (rk_last_a[g] !== (e.idx == 7'(t-1))) begin
               errors++; $display("FAIL rk_last cfg%0d idx%0d got %b want %b", g, e.idx, rk_last_a[g], (e.idx == 7'(t-1)));
            end
            got_keys[seen] = rk_data_a[g];
            seen++;
            was_stall = 1'b0;
         end else begin
            held_dat  = rk_data_a[g];
            held_idx  = rk_idx_a[g];
            was_stall = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      key_valid_a[g] = 1'b0; rk_ready_a[g] = 1'b0;
      checks++;
      if (seen != t) begin
         errors++; $display("FAIL stream_len cfg%0d got %0d keys want %0d", g, seen, t);
      end
      checks++;
      if (key_ready_a[g] !== 1'b1) begin
         errors++; $display("FAIL key_ready_after_last cfg%0d got %b want 1", g, key_ready_a[g]);
      end
      checks++;
      if (rk_valid_a[g] !== 1'b0) begin
         errors++; $display("FAIL rk_valid_after_last cfg%0d got %b want 0", g, rk_valid_a[g]);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int g = 0; g < NCFG; g++) begin
         checks++;
         if (key_ready_a[g] !== 1'b0) begin
            errors++; $display("FAIL reset_key_ready cfg%0d got %b want 0", g, key_ready_a[g]);
         end
         checks++;
         if ({rk_valid_a[g], rk_last_a[g], rk_idx_a[g], rk_data_a[g]} !== 73'd0) begin
            errors++; $display("FAIL reset_outputs cfg%0d got v%b l%b i%0d d%h want all 0",
                               g, rk_valid_a[g], rk_last_a[g], rk_idx_a[g], rk_data_a[g]);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      for (int g = 0; g < NCFG; g++) begin
         checks++;
         if (key_ready_a[g] !== 1'b1) begin
            errors++; $display("FAIL idle_key_ready cfg%0d got %b want 1", g, key_ready_a[g]);
         end
      end
   endtask

   task automatic test_vector16();
      logic [15:0] kv [6];
      kv = '{16'h0100, 16'h0908, 16'h1110, 16'h1918, 16'h71c3, 16'hb649};
      stream(0, 256'h1918111009080100, 0, 1'b0, '0, -1);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (got_keys[i] !== 64'(kv[i])) begin
            errors++; $display("FAIL vector16_k%0d got %h want %h", i, got_keys[i], kv[i]);
         end
      end
   endtask

`ifdef SIMON_KEY_STORE_EN
   task automatic test_store();
      int cyc;
      @(negedge clk); rd_addr_a[0] = 7'd4;
      @(negedge clk);
      checks++;
      if (rd_data_a[0] !== 64'h71c3) begin
         errors++; $display("FAIL store_rd4 got %h want 71c3", rd_data_a[0]);
      end
      checks++;
      if (keys_done_a[0] !== 1'b1) begin
         errors++; $display("FAIL keys_done_set got %b want 1", keys_done_a[0]);
      end
      rd_addr_a[0] = 7'd5;
      @(negedge clk);
      checks++;
      if (rd_data_a[0] !== 64'hb649) begin
         errors++; $display("FAIL store_rd5 got %h want b649", rd_data_a[0]);
      end
      rd_addr_a[0] = 7'd40;
      @(negedge clk);
      checks++;
      if (rd_data_a[0] !== 64'd0) begin
         errors++; $display("FAIL store_rd_oob got %h want 0", rd_data_a[0]);
      end
      key_in_a[0] = rand_key(); key_valid_a[0] = 1'b1;
      @(negedge clk);
      key_valid_a[0] = 1'b0;
      checks++;
      if (keys_done_a[0] !== 1'b0) begin
         errors++; $display("FAIL keys_done_clear got %b want 0", keys_done_a[0]);
      end
      rk_ready_a[0] = 1'b1;
      cyc = 0;
      while (rk_valid_a[0] === 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      rk_ready_a[0] = 1'b0;
      checks++;
      if (rk_valid_a[0] !== 1'b0) begin
         errors++; $display("FAIL store_drain rk_valid got %b want 0", rk_valid_a[0]);
      end
   endtask
`endif

   task automatic test_cipher64();
      logic [127:0] ct;
      stream(7, 256'h0f0e0d0c0b0a09080706050403020100, 0, 1'b0, '0, -1);
      ct = simon128_enc(128'h63736564207372656c6c657661727420);
      checks++;
      if (ct !== 128'h49681b1e1e54fe3f65aa832af84e0bbc) begin
         errors++; $display("FAIL cipher64 got %h want 49681b1e1e54fe3f65aa832af84e0bbc", ct);
      end
   endtask

   task automatic test_stalls();
      for (int g = 0; g < NCFG; g++) stream(g, rand_key(), 30, 1'b0, '0, -1);
   endtask

   task automatic test_key_ignored();
      stream(0, rand_key(), 0, 1'b1, rand_key(), -1);
   endtask

   task automatic test_reset_mid();
      stream(0, rand_key(), 0, 1'b0, '0, 10);
      stream(0, rand_key(), 0, 1'b0, '0, -1);
   endtask

   initial begin
      rst = 1'b1;
      for (int g = 0; g < NCFG; g++) begin
         key_in_a[g] = '0; key_valid_a[g] = 1'b0; rk_ready_a[g] = 1'b0;
`ifdef SIMON_KEY_STORE_EN
         rd_addr_a[g] = '0;
`endif
      end
      test_reset();
      test_vector16();
`ifdef SIMON_KEY_STORE_EN
      test_store();
`endif
      test_cipher64();
      test_stalls();
      test_key_ignored();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/simon_key_expand.md
# simon_key_expand

Parametrised, sequential Simon key-schedule engine for all ten Simon block/key configurations. It accepts a master key over a valid/ready handshake and streams the T round keys k[0]..k[T-1] over a second valid/ready handshake, one per cycle, with backpressure. It sits between the key-load interface and the round datapath, which consumes round keys in order.

## Interface

Parameters:
- N, 16: word width in bits; legal values 16, 24, 32, 48, 64.
- M, 4: key words; legal pairs (N,M): (16,4) (24,3) (24,4) (32,3) (32,4) (48,2) (48,3) (64,2) (64,3) (64,4); any other pair is an elaboration error.
- T, derived localparam: 32, 36, 36, 42, 44, 52, 54, 68, 69, 72 for the pairs above, in order.
- ZJ, derived localparam: z index 0, 0, 1, 2, 3, 2, 3, 2, 3, 4 for the pairs above, in order.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- key_in  in  M*N  master key; key_in[N-1:0] = k[0], key_in[M*N-1:(M-1)*N] = k[M-1].
- key_valid  in  1  key_in valid.
- key_ready  out  1  high in IDLE, low in RUN and while rst is high.
- rk_data  out  N  current round key.
- rk_idx  out  7  index of rk_data, 0..T-1.
- rk_valid  out  1  rk_data/rk_idx valid.
- rk_ready  in  1  consumer accepts.
- rk_last  out  1  rk_valid and rk_idx == T-1.

## Operation

- States: IDLE, RUN. Reset → IDLE; every output register cleared: rk_data 0, rk_idx 0, rk_valid 0.
- IDLE: on key_valid && key_ready, load the M-word window W[0..M-1] = k[0..M-1], rk_idx ← 0, → RUN.
- RUN: rk_valid = 1, rk_data = W[0]. On rk_valid && rk_ready: shift W down one word, W[M-1] ← knew, rk_idx ← rk_idx+1. If rk_idx == T-1 at that handshake, → IDLE, rk_valid ← 0.
- knew, with window index i = rk_idx (the new word is k[i+M]): tmp = ror(W[M-1],3); for M=4, tmp ^= W[1]; tmp ^= ror(tmp,1); knew = W[0] ^ tmp ^ c ^ zbit, where c = 2^N − 4 (N bits), i.e. ~W[0] ^ tmp ^ 3 ^ zbit.
- zbit = Z[ZJ][(rk_idx) mod 62]; the z0..z4 constants are stored 62 bits wide with bit 0 = first element of the published sequence. Modulo via a wrapping 6-bit counter (61 → 0), not a divider.
- The window keeps computing beyond T−M shifts; those words are never emitted.
- All rotates and XORs are exactly N bits; no carries.
- key_valid is ignored in RUN; no preemption. rst mid-RUN aborts immediately with no further rk_valid.

## Timing

- Key handshake in cycle 0 → rk_valid = 1 with k[0] in cycle 1.
- With rk_ready held high: one round key per cycle; k[T-1] in cycle T; key_ready = 1 in cycle T+1; next key accepted at earliest in cycle T+1.
- rk_ready low: rk_data, rk_idx, rk_valid hold unchanged.
- All outputs registered or decoded from registered state only; no combinational path from rk_ready or key_valid to any output.

## Configuration

- SIMON_KEY_STORE_EN defined: adds a T×N round-key store written on each rk handshake, plus ports rd_addr (in, 7), rd_data (out, N, registered, 1-cycle latency, 0 for rd_addr ≥ T) and keys_done (out, 1; set on the rk_last handshake, cleared on the next key load or rst). The store's contents are not cleared by rst.
- Undefined: no store or extra ports; streaming behaviour is identical.

## Test plan

- N=16, M=4, key 64'h1918111009080100, rk_ready = 1 → k0..k5 = 0100, 0908, 1110, 1918, 71c3, b649; 32 keys; rk_last on idx 31; key_ready high one cycle later.
- N=64, M=2, key 128'h0f0e0d0c0b0a09080706050403020100 → 68 keys; ciphertext 49681b1e1e54fe3f65aa832af84e0bbc from a golden-model encrypt of 128'h63736564207372656c6c657661727420 using the streamed keys.
- Random rk_ready stalls (30% low) on all ten configurations → key sequence identical to the unstalled run; rk_data stable throughout stalls.
- key_valid held high during RUN with a different key → ignored; the stream completes unchanged.
- rst asserted at idx 10 → rk_valid = 0 the following cycle; a new key then streams from k[0] correctly.
- With SIMON_KEY_STORE_EN: after the stream completes, rd_addr = 4 → rd_data = 71c3 one cycle later; keys_done = 1 until the next load.
